// File: rtl/ralu_core.sv
`default_nettype none
// ============================================================================
//  Module      : ralu_core
//  Description : 4-bit register-ALU datapath of the central unit. It holds
//                operand register A, operand/shift register B, an 8x4
//                general-purpose register bank (GPRB) and a combinational
//                ALU with 16 logic and 16 arithmetic functions. The control
//                unit drives it with microcommands every clock cycle.
//
//  Ports
//    clock   in   1  system clock, rising-edge active
//    reset   in   1  asynchronous active-high clear of A, B and the GPRB
//    DataIn  in   4  external data operand
//    S       in   4  ALU function select
//    M       in   1  0 = logic mode, 1 = arithmetic mode
//    Pin     in   1  carry in (arithmetic mode only)
//    ISR     in   1  serial bit entering B[3] on a right shift
//    ISL     in   1  serial bit entering B[0] on a left shift
//    A       in   1  source select: 1 = DataIn, 0 = GPRB[adr]
//    wr      in   1  write R into GPRB[adr]
//    adr     in   3  GPRB read/write address
//    v       in   4  register microcommands
//                    v[0] load A, v[1] enable B, v[2] load(1)/shift(0) B,
//                    v[3] shift right(1)/left(0)
//    OSR     out  1  B[0], bit leaving on a right shift
//    OSL     out  1  B[3], bit leaving on a left shift
//    Pout    out  1  carry out of the arithmetic sum, 0 in logic mode
//    R       out  4  ALU result
//
//  Revision    : 1.0  initial release
// ============================================================================
module ralu_core (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] DataIn,
    input  logic [3:0] S,
    input  logic       M,
    input  logic       Pin,
    input  logic       ISR,
    input  logic       ISL,
    input  logic       A,
    input  logic       wr,
    input  logic [2:0] adr,
    input  logic [3:0] v,
    output logic       OSR,
    output logic       OSL,
    output logic       Pout,
    output logic [3:0] R
);

    localparam int c_DEPTH = 8;

    logic [3:0] r_a;
    logic [3:0] r_b;
    logic [3:0] r_gprb [c_DEPTH];

    logic [3:0] w_src;
    logic [3:0] w_logic;
    logic [4:0] w_x;
    logic [4:0] w_sum;
    logic [4:0] w_a5;
    logic [4:0] w_or5;
    logic [4:0] w_orn5;
    logic [4:0] w_and5;
    logic [4:0] w_andn5;

    // Asynchronous read of the register bank feeds both operand registers.
    assign w_src = A ? DataIn : r_gprb[adr];

    // ------------------------------------------------------------------------
    // Operand registers and register bank. Every update samples pre-edge
    // values, so a GPRB write of R, an A load and a B load/shift may all
    // happen in the same cycle.
    // ------------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_a <= 4'd0;
            r_b <= 4'd0;
            for (int i = 0; i < c_DEPTH; i++) begin
                r_gprb[i] <= 4'd0;
            end
        end else begin
            if (v[0]) begin
                r_a <= w_src;
            end
            if (v[1]) begin
                if (v[2]) begin
                    r_b <= w_src;
                end else if (v[3]) begin
                    r_b <= {ISR, r_b[3:1]};
                end else begin
                    r_b <= {r_b[2:0], ISL};
                end
            end
            if (wr) begin
                r_gprb[adr] <= R;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Logic functions
    // ------------------------------------------------------------------------
    always_comb begin
        w_logic = 4'd0;
        case (S)
            4'h0: w_logic = r_a;
            4'h1: w_logic = r_b;
            4'h2: w_logic = ~r_a;
            4'h3: w_logic = ~r_b;
            4'h4: w_logic = r_a & r_b;
            4'h5: w_logic = r_a | r_b;
            4'h6: w_logic = r_a ^ r_b;
            4'h7: w_logic = ~(r_a & r_b);
            4'h8: w_logic = ~(r_a | r_b);
            4'h9: w_logic = ~(r_a ^ r_b);
            4'hA: w_logic = r_a & ~r_b;
            4'hB: w_logic = ~r_a & r_b;
            4'hC: w_logic = r_a | ~r_b;
            4'hD: w_logic = ~r_a | r_b;
            4'hE: w_logic = 4'b0000;
            4'hF: w_logic = 4'b1111;
            default: w_logic = 4'd0;
        endcase
    end

    // ------------------------------------------------------------------------
    // Arithmetic functions. Terms are widened to 5 bits so that the two-term
    // sums plus the carry in (at most 15+15+1) keep their carry in bit 4.
    // ------------------------------------------------------------------------
    assign w_a5    = {1'b0, r_a};
    assign w_or5   = {1'b0, r_a | r_b};
    assign w_orn5  = {1'b0, r_a | ~r_b};
    assign w_and5  = {1'b0, r_a & r_b};
    assign w_andn5 = {1'b0, r_a & ~r_b};

    always_comb begin
        w_x = 5'd0;
        case (S)
            4'h0: w_x = w_a5;
            4'h1: w_x = w_or5;
            4'h2: w_x = w_orn5;
            4'h3: w_x = 5'b01111;
            4'h4: w_x = w_a5 + w_andn5;
            4'h5: w_x = w_or5 + w_andn5;
            4'h6: w_x = w_a5 + {1'b0, ~r_b};
            4'h7: w_x = w_andn5 + 5'b01111;
            4'h8: w_x = w_a5 + w_and5;
            4'h9: w_x = w_a5 + {1'b0, r_b};
            4'hA: w_x = w_orn5 + w_and5;
            4'hB: w_x = w_and5 + 5'b01111;
            4'hC: w_x = w_a5 + w_a5;
            4'hD: w_x = w_or5 + w_a5;
            4'hE: w_x = w_orn5 + w_a5;
            4'hF: w_x = w_a5 + 5'b01111;
            default: w_x = 5'd0;
        endcase
    end

    assign w_sum = w_x + {4'd0, Pin};

    assign R    = M ? w_sum[3:0] : w_logic;
    assign Pout = M & w_sum[4];
    assign OSR  = r_b[0];
    assign OSL  = r_b[3];

endmodule
`default_nettype wire

// File: tb/tb_ralu_core.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ralu_core
//  Description : Self-checking bench for ralu_core. Stimulus pushes the
//                hand-computed expected {R, Pout, OSR, OSL} into a queue while
//                the inputs for a cycle are applied; a monitor pops and
//                compares at the following falling edge.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ralu_core;

    logic       clock;
    logic       reset;
    logic [3:0] DataIn;
    logic [3:0] S;
    logic       M;
    logic       Pin;
    logic       ISR;
    logic       ISL;
    logic       A;
    logic       wr;
    logic [2:0] adr;
    logic [3:0] v;
    logic       OSR;
    logic       OSL;
    logic       Pout;
    logic [3:0] R;

    // Expected {R[3:0], Pout, OSR, OSL}
    logic [6:0] exp_q [$];
    string      name_q [$];

    int n_checks = 0;
    int n_fail   = 0;

    ralu_core dut (
        .clock  (clock),
        .reset  (reset),
        .DataIn (DataIn),
        .S      (S),
        .M      (M),
        .Pin    (Pin),
        .ISR    (ISR),
        .ISL    (ISL),
        .A      (A),
        .wr     (wr),
        .adr    (adr),
        .v      (v),
        .OSR    (OSR),
        .OSL    (OSL),
        .Pout   (Pout),
        .R      (R)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Monitor: one expectation is consumed per falling edge.
    always @(negedge clock) begin
        if (exp_q.size() > 0) begin
            logic [6:0] e;
            logic [6:0] got;
            string      nm;
            e   = exp_q.pop_front();
            nm  = name_q.pop_front();
            got = {R, Pout, OSR, OSL};
            n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL %s: got R=%h Pout=%b OSR=%b OSL=%b, expected R=%h Pout=%b OSR=%b OSL=%b",
                         nm, got[6:3], got[2], got[1], got[0], e[6:3], e[2], e[1], e[0]);
            end
        end
    end

    task automatic expect_out(input string nm, input logic [3:0] r, input logic p,
                              input logic osr, input logic osl);
        exp_q.push_back({r, p, osr, osl});
        name_q.push_back(nm);
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    // Idle control: no register update, no write.
    task automatic idle(input logic [3:0] s, input logic m, input logic p);
        v   = 4'b0000;
        wr  = 1'b0;
        S   = s;
        M   = m;
        Pin = p;
    endtask

    initial begin
        reset = 1'b0; DataIn = 4'd0; S = 4'd0; M = 1'b0; Pin = 1'b0;
        ISR = 1'b0; ISL = 1'b0; A = 1'b0; wr = 1'b0; adr = 3'd0; v = 4'd0;
        #1 reset = 1'b1;
        cyc();

        // Reset state
        expect_out("reset_R_A", 4'd0, 1'b0, 1'b0, 1'b0);
        cyc();
        idle(4'h1, 1'b0, 1'b0);
        expect_out("reset_B", 4'd0, 1'b0, 1'b0, 1'b0);
        cyc();
        reset = 1'b0;
        for (int k = 0; k < 8; k++) begin
            A = 1'b0; adr = 3'(k); v = 4'b0001; wr = 1'b0;
            cyc();
            idle(4'h0, 1'b0, 1'b0);
            expect_out($sformatf("reset_gprb%0d", k), 4'd0, 1'b0, 1'b0, 1'b0);
            cyc();
        end

        // Load A from DataIn, write through R into GPRB[0] and GPRB[1]
        A = 1'b1; DataIn = 4'd3; v = 4'b0001;
        cyc();
        idle(4'h0, 1'b0, 1'b0); wr = 1'b1; adr = 3'd0;
        expect_out("loadA_3", 4'd3, 1'b0, 1'b0, 1'b0);
        cyc();
        wr = 1'b0; DataIn = 4'd12; v = 4'b0001;
        cyc();
        idle(4'h0, 1'b0, 1'b0); wr = 1'b1; adr = 3'd1;
        expect_out("loadA_12", 4'd12, 1'b0, 1'b0, 1'b0);
        cyc();

        // A <= GPRB[0], B <= GPRB[1], then A+B written back to GPRB[1]
        wr = 1'b0; A = 1'b0; adr = 3'd0; v = 4'b0001;
        cyc();
        adr = 3'd1; v = 4'b0110;
        cyc();
        idle(4'h9, 1'b1, 1'b0); wr = 1'b1; adr = 3'd1;
        expect_out("add_3_12", 4'd15, 1'b0, 1'b0, 1'b1);
        cyc();
        idle(4'h1, 1'b0, 1'b0);
        expect_out("B_is_12", 4'd12, 1'b0, 1'b0, 1'b1);
        cyc();

        // B <= 3 then three left shifts with ISL=0; OR into GPRB[0] on the last
        A = 1'b0; adr = 3'd0; v = 4'b0110;
        cyc();
        v = 4'b0010; ISL = 1'b0; S = 4'h1; M = 1'b0;
        expect_out("shl_B3", 4'd3, 1'b0, 1'b1, 1'b0);
        cyc();
        expect_out("shl_B6", 4'd6, 1'b0, 1'b0, 1'b0);
        cyc();
        S = 4'h5; wr = 1'b1; adr = 3'd0;
        expect_out("shl_or_wr", 4'd15, 1'b0, 1'b0, 1'b1);
        cyc();
        idle(4'h1, 1'b0, 1'b0);
        expect_out("shl_B8", 4'd8, 1'b0, 1'b0, 1'b1);
        cyc();

        // A <= GPRB[1] (=15, written back earlier); B = 8
        A = 1'b0; adr = 3'd1; v = 4'b0001;
        cyc();
        idle(4'h0, 1'b0, 1'b0);
        expect_out("gprb1_15", 4'd15, 1'b0, 1'b0, 1'b1);
        cyc();
        idle(4'h4, 1'b0, 1'b0); expect_out("and_15_8", 4'd8, 1'b0, 1'b0, 1'b1); cyc();
        idle(4'h9, 1'b1, 1'b1); expect_out("add_15_8_c", 4'd8, 1'b1, 1'b0, 1'b1); cyc();
        idle(4'h0, 1'b1, 1'b0); expect_out("ar_A", 4'd15, 1'b0, 1'b0, 1'b1); cyc();
        idle(4'h0, 1'b1, 1'b1); expect_out("ar_A_inc_wrap", 4'd0, 1'b1, 1'b0, 1'b1); cyc();
        idle(4'h6, 1'b1, 1'b0); expect_out("ar_A_plus_nB", 4'd6, 1'b1, 1'b0, 1'b1); cyc();
        idle(4'h7, 1'b1, 1'b0); expect_out("ar_AnB_m1", 4'd6, 1'b1, 1'b0, 1'b1); cyc();
        idle(4'hC, 1'b1, 1'b0); expect_out("ar_A_plus_A", 4'd14, 1'b1, 1'b0, 1'b1); cyc();
        idle(4'h5, 1'b1, 1'b0); expect_out("ar_or_AnB", 4'd6, 1'b1, 1'b0, 1'b1); cyc();
        idle(4'h3, 1'b1, 1'b0); expect_out("ar_all_ones", 4'd15, 1'b0, 1'b0, 1'b1); cyc();
        idle(4'h6, 1'b0, 1'b1); expect_out("lg_xor", 4'd7, 1'b0, 1'b0, 1'b1); cyc();
        idle(4'hE, 1'b0, 1'b0); expect_out("lg_zero", 4'd0, 1'b0, 1'b0, 1'b1); cyc();
        idle(4'hF, 1'b0, 1'b0); expect_out("lg_ones", 4'd15, 1'b0, 1'b0, 1'b1); cyc();
        idle(4'hD, 1'b0, 1'b0); expect_out("lg_nA_or_B", 4'd8, 1'b0, 1'b0, 1'b1); cyc();
        idle(4'h8, 1'b0, 1'b0); expect_out("lg_nor", 4'd0, 1'b0, 1'b0, 1'b1); cyc();

        // B <= 1, right shift with ISR=1
        A = 1'b1; DataIn = 4'd1; v = 4'b0110;
        cyc();
        v = 4'b1010; ISR = 1'b1; S = 4'h1; M = 1'b0;
        expect_out("shr_B1", 4'd1, 1'b0, 1'b1, 1'b0);
        cyc();
        idle(4'h1, 1'b0, 1'b0);
        expect_out("shr_B8", 4'd8, 1'b0, 1'b0, 1'b1);
        cyc();

        // Reset asserted mid-cycle while another shift is commanded
        v = 4'b1010; ISR = 1'b1;
        #2 reset = 1'b1;
        expect_out("midreset_B", 4'd0, 1'b0, 1'b0, 1'b0);
        cyc();
        idle(4'h0, 1'b0, 1'b0);
        expect_out("midreset_A", 4'd0, 1'b0, 1'b0, 1'b0);
        cyc();
        reset = 1'b0;
        for (int k = 0; k < 2; k++) begin
            A = 1'b0; adr = 3'(k); v = 4'b0001;
            cyc();
            idle(4'h0, 1'b0, 1'b0);
            expect_out($sformatf("midreset_gprb%0d", k), 4'd0, 1'b0, 1'b0, 1'b0);
            cyc();
        end

        // Drain the scoreboard with a bounded wait
        for (int t = 0; t < 4 && exp_q.size() > 0; t++) begin
            @(negedge clock);
            #1;
        end
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
